// File: rtl/ev22_register_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : ev22_register_bank_if
// Description : Write-back, peripheral and readout bundle for the EV22
//               register bank.
// Revision    : 1.0
// ============================================================================
interface ev22_register_bank_if #(
  parameter int DATA_WIDTH = 16
);
  logic                       updateBlock;
  logic                       Wr_En;
  logic [5:0]                 Sel_W;
  logic [DATA_WIDTH-1:0]      Data_W;
  logic                       Wr_WReg;
  logic [DATA_WIDTH-1:0]      Data_WReg;
  logic [DATA_WIDTH-1:0]      PI0;
  logic [DATA_WIDTH-1:0]      PI1;
  logic                       Err_Clr;
  logic [32*DATA_WIDTH-1:0]   Regs_Flat;
  logic [DATA_WIDTH-1:0]      Working_Register;
  logic [DATA_WIDTH-1:0]      PO0;
  logic [DATA_WIDTH-1:0]      PO1;
  logic                       Wr_Err;

  modport master (
    output updateBlock, Wr_En, Sel_W, Data_W, Wr_WReg, Data_WReg,
           PI0, PI1, Err_Clr,
    input  Regs_Flat, Working_Register, PO0, PO1, Wr_Err
  );

  modport slave (
    input  updateBlock, Wr_En, Sel_W, Data_W, Wr_WReg, Data_WReg,
           PI0, PI1, Err_Clr,
    output Regs_Flat, Working_Register, PO0, PO1, Wr_Err
  );
endinterface
`default_nettype wire

// File: rtl/ev22_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : ev22_register_bank
// Description : Architectural registers r0..r34 with synchronized peripheral
//               inputs, output ports and sticky illegal-write flag.
// Revision    : 1.0
// ============================================================================
module ev22_register_bank #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] W_RESET     = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  ev22_register_bank_if.slave    bus
);

  localparam int NUM_GP = 28;

  logic [DATA_WIDTH-1:0]    gp_q     [NUM_GP];
  logic [DATA_WIDTH-1:0]    pi0_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]    pi1_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]    po0_q;
  logic [DATA_WIDTH-1:0]    po1_q;
  logic [DATA_WIDTH-1:0]    w_q;
  logic                     err_q;
  logic                     commit;
  logic                     wreg_commit;
  logic                     sel_illegal;
  logic [32*DATA_WIDTH-1:0] regs_flat;

  assign commit      = bus.updateBlock & bus.Wr_En;
  assign wreg_commit = bus.updateBlock & bus.Wr_WReg;
  // 28/29 are read-only but legal, so they are excluded from the error set
  assign sel_illegal = (bus.Sel_W == 6'd30) | (bus.Sel_W == 6'd31) |
                       (bus.Sel_W > 6'd34);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GP; i++) begin
        gp_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_GP; i++) begin
        if (bus.Sel_W == 6'(i)) begin
          gp_q[i] <= bus.Data_W;
        end
      end
    end
  end

  // Synchronizers run regardless of updateBlock
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        pi0_sync[k] <= '0;
        pi1_sync[k] <= '0;
      end
    end else begin
      pi0_sync[0] <= bus.PI0;
      pi1_sync[0] <= bus.PI1;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        pi0_sync[k] <= pi0_sync[k-1];
        pi1_sync[k] <= pi1_sync[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      po0_q <= '0;
      po1_q <= '0;
    end else if (commit) begin
      if (bus.Sel_W == 6'd32) begin
        po0_q <= bus.Data_W;
      end
      if (bus.Sel_W == 6'd33) begin
        po1_q <= bus.Data_W;
      end
    end
  end

  // Dedicated working-register write takes priority over an indexed one
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= W_RESET;
    end else if (wreg_commit) begin
      w_q <= bus.Data_WReg;
    end else if (commit && (bus.Sel_W == 6'd34)) begin
      w_q <= bus.Data_W;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (commit && sel_illegal) begin
      err_q <= 1'b1;
    end else if (bus.Err_Clr) begin
      err_q <= 1'b0;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_GP; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = gp_q[i];
    end
    regs_flat[28*DATA_WIDTH +: DATA_WIDTH] = pi0_sync[SYNC_STAGES-1];
    regs_flat[29*DATA_WIDTH +: DATA_WIDTH] = pi1_sync[SYNC_STAGES-1];
    regs_flat[30*DATA_WIDTH +: DATA_WIDTH] = po0_q;
    regs_flat[31*DATA_WIDTH +: DATA_WIDTH] = po1_q;
  end

  assign bus.Regs_Flat        = regs_flat;
  assign bus.Working_Register = w_q;
  assign bus.PO0              = po0_q;
  assign bus.PO1              = po1_q;
  assign bus.Wr_Err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ev22_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_ev22_register_bank
// Description : Directed and randomized checks of ev22_register_bank against
//               an address-indexed behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_ev22_register_bank;
  localparam int          DW = 16;
  localparam int          SS = 2;
  localparam logic [15:0] WR = 16'h0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ev22_register_bank_if #(.DATA_WIDTH(DW)) bus ();

  ev22_register_bank #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS),
    .W_RESET    (WR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Model: registers indexed by architectural address, PI delay lines as queues
  logic [DW-1:0] m_reg [0:63];
  logic          m_err;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  function automatic logic [DW-1:0] exp_word(int i);
    if (i < 28)       return m_reg[i];
    else if (i == 28) return q0[0];
    else if (i == 29) return q1[0];
    else if (i == 30) return m_reg[32];
    else              return m_reg[33];
  endfunction

  task automatic idle();
    bus.updateBlock = 1'b0;
    bus.Wr_En       = 1'b0;
    bus.Sel_W       = 6'd0;
    bus.Data_W      = '0;
    bus.Wr_WReg     = 1'b0;
    bus.Data_WReg   = '0;
    bus.Err_Clr     = 1'b0;
  endtask

  task automatic tick();
    int s;
    bit set;
    set = 1'b0;
    if (reset) begin
      for (int i = 0; i < 64; i++) m_reg[i] = '0;
      m_reg[34] = WR;
      m_err = 1'b0;
      q0 = {};
      q1 = {};
      repeat (SS) begin
        q0.push_back('0);
        q1.push_back('0);
      end
    end else begin
      q0.push_back(bus.PI0);
      q1.push_back(bus.PI1);
      void'(q0.pop_front());
      void'(q1.pop_front());
      if (bus.updateBlock) begin
        if (bus.Wr_En) begin
          s = int'(bus.Sel_W);
          if (s <= 27 || s == 32 || s == 33) m_reg[s] = bus.Data_W;
          else if (s == 34) begin
            if (!bus.Wr_WReg) m_reg[34] = bus.Data_W;
          end else if (s != 28 && s != 29) set = 1'b1;
        end
        if (bus.Wr_WReg) m_reg[34] = bus.Data_WReg;
      end
      if (set) m_err = 1'b1;
      else if (bus.Err_Clr) m_err = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus.Regs_Flat[i*DW +: DW] !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_word%0d got %h want 0000", i, bus.Regs_Flat[i*DW +: DW]);
      end
    end
    vectors++;
    if (bus.Working_Register !== WR) begin
      miscompares++;
      $display("FAIL reset_wreg got %h want %h", bus.Working_Register, WR);
    end
    vectors++;
    if (bus.PO0 !== 16'h0 || bus.PO1 !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_po got %h/%h want 0000/0000", bus.PO0, bus.PO1);
    end
    vectors++;
    if (bus.Wr_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err got %b want 0", bus.Wr_Err);
    end
  endtask

  task automatic test_write_commit();
    bus.updateBlock = 1'b1;
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd5;
    bus.Data_W = 16'hBEEF;
    vectors++;
    if (bus.Regs_Flat[95:80] !== 16'h0000) begin
      miscompares++;
      $display("FAIL no_bypass got %h want 0000", bus.Regs_Flat[95:80]);
    end
    tick();
    idle();
    vectors++;
    if (bus.Regs_Flat[95:80] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL write_r5 got %h want beef", bus.Regs_Flat[95:80]);
    end
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd5;
    bus.Data_W = 16'h1234;
    bus.Wr_WReg = 1'b1;
    bus.Data_WReg = 16'h5555;
    tick();
    idle();
    vectors++;
    if (bus.Regs_Flat[95:80] !== 16'hBEEF || bus.Working_Register !== WR) begin
      miscompares++;
      $display("FAIL gated_write got %h/%h want beef/%h", bus.Regs_Flat[95:80],
               bus.Working_Register, WR);
    end
  endtask

  task automatic test_wreg_priority();
    bus.updateBlock = 1'b1;
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd34;
    bus.Data_W = 16'h1111;
    bus.Wr_WReg = 1'b1;
    bus.Data_WReg = 16'h2222;
    tick();
    idle();
    vectors++;
    if (bus.Working_Register !== 16'h2222 || bus.Wr_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL wreg_priority got %h err %b want 2222 err 0",
               bus.Working_Register, bus.Wr_Err);
    end
    bus.updateBlock = 1'b1;
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd32;
    bus.Data_W = 16'h00A5;
    bus.Wr_WReg = 1'b1;
    bus.Data_WReg = 16'h3333;
    tick();
    idle();
    vectors++;
    if (bus.PO0 !== 16'h00A5 || bus.Working_Register !== 16'h3333) begin
      miscompares++;
      $display("FAIL po0_dual got %h/%h want 00a5/3333", bus.PO0, bus.Working_Register);
    end
  endtask

  task automatic test_pi_sync();
    bus.PI0 = 16'h7E81;
    tick();
    vectors++;
    if (bus.Regs_Flat[28*DW +: DW] !== 16'h0000) begin
      miscompares++;
      $display("FAIL pi_stage1 got %h want 0000", bus.Regs_Flat[28*DW +: DW]);
    end
    tick();
    vectors++;
    if (bus.Regs_Flat[28*DW +: DW] !== 16'h7E81) begin
      miscompares++;
      $display("FAIL pi_stage2 got %h want 7e81", bus.Regs_Flat[28*DW +: DW]);
    end
    bus.updateBlock = 1'b1;
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd28;
    bus.Data_W = 16'hFFFF;
    tick();
    idle();
    vectors++;
    if (bus.Regs_Flat[28*DW +: DW] !== 16'h7E81 || bus.Wr_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL ro_write got %h err %b want 7e81 err 0",
               bus.Regs_Flat[28*DW +: DW], bus.Wr_Err);
    end
  endtask

  task automatic test_wr_err();
    bus.updateBlock = 1'b1;
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd31;
    bus.Data_W = 16'hDEAD;
    tick();
    vectors++;
    if (bus.Wr_Err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set got %b want 1", bus.Wr_Err);
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus.Regs_Flat[i*DW +: DW] !== exp_word(i)) begin
        miscompares++;
        $display("FAIL err_nochange_w%0d got %h want %h", i,
                 bus.Regs_Flat[i*DW +: DW], exp_word(i));
      end
    end
    bus.Sel_W = 6'd40;
    bus.Err_Clr = 1'b1;
    tick();
    vectors++;
    if (bus.Wr_Err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set_wins got %b want 1", bus.Wr_Err);
    end
    idle();
    bus.Err_Clr = 1'b1;
    tick();
    idle();
    vectors++;
    if (bus.Wr_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got %b want 0", bus.Wr_Err);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.updateBlock = 1'b1;
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd3;
    bus.Data_W = 16'hAAAA;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    vectors++;
    if (bus.Regs_Flat[63:48] !== 16'h0000 || bus.PO0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid got %h/%h want 0000/0000", bus.Regs_Flat[63:48], bus.PO0);
    end
    bus.updateBlock = 1'b1;
    bus.Wr_En = 1'b1;
    bus.Sel_W = 6'd3;
    bus.Data_W = 16'h5A5A;
    tick();
    idle();
    vectors++;
    if (bus.Regs_Flat[63:48] !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL post_reset_write got %h want 5a5a", bus.Regs_Flat[63:48]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.updateBlock = ($urandom_range(0, 3) != 0);
      bus.Wr_En = $urandom_range(0, 1) == 1;
      bus.Sel_W = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(28, 63))
                                              : 6'($urandom_range(0, 34));
      bus.Data_W = 16'($urandom);
      bus.Wr_WReg = ($urandom_range(0, 3) == 0);
      bus.Data_WReg = 16'($urandom);
      bus.Err_Clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) bus.PI0 = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bus.PI1 = 16'($urandom);
      tick();
      for (int i = 0; i < 32; i++) begin
        vectors++;
        if (bus.Regs_Flat[i*DW +: DW] !== exp_word(i)) begin
          miscompares++;
          $display("FAIL rand%0d_w%0d got %h want %h", n, i,
                   bus.Regs_Flat[i*DW +: DW], exp_word(i));
        end
      end
      vectors++;
      if (bus.Working_Register !== m_reg[34]) begin
        miscompares++;
        $display("FAIL rand%0d_wreg got %h want %h", n, bus.Working_Register, m_reg[34]);
      end
      vectors++;
      if (bus.PO0 !== m_reg[32] || bus.PO1 !== m_reg[33]) begin
        miscompares++;
        $display("FAIL rand%0d_po got %h/%h want %h/%h", n, bus.PO0, bus.PO1,
                 m_reg[32], m_reg[33]);
      end
      vectors++;
      if (bus.Wr_Err !== m_err) begin
        miscompares++;
        $display("FAIL rand%0d_err got %b want %b", n, bus.Wr_Err, m_err);
      end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.PI0 = '0;
    bus.PI1 = '0;
    #1;
    test_reset();
    test_write_commit();
    test_wreg_priority();
    test_pi_sync();
    test_wr_err();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
